pedometer_core: RTL and testbench

Parametrised second-generation pedometer datapath. Accepts two-axis acceleration samples (A, B), forms a magnitude, runs it through a TAPS-deep FIR whose weights live in a dual-write weight file, and counts steps with a hysteresis-threshold detector. It sits between the sensor sample interface and the system bus that reads step_count. It keeps the existing weight-update port set (updateWeight / dualUpdateWeights / Addr / Data) and adds streaming samples, a filtered output and configurable step detection.

---
 rtl/pedometer_pkg.sv | 26 ++
 rtl/pedometer_weight_file.sv | 45 ++++
 rtl/pedometer_core.sv | 181 ++++++++++++++++++
 tb/tb_pedometer_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pedometer_pkg.sv
// pedometer_pkg: shared types and defaults for the pedometer datapath.
//   det_state_e : step detector state (ST_BELOW / ST_ABOVE)
//   DEF_*       : default parameter values
//   acc_width() : full-precision FIR accumulator width
package pedometer_pkg;

    typedef enum logic [0:0] {
        ST_BELOW = 1'b0,
        ST_ABOVE = 1'b1
    } det_state_e;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_W_W     = 8;
    localparam int unsigned DEF_TAPS    = 8;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_MIN_GAP = 4;

    // Magnitude is DATA_W+1 bits; each product adds W_W bits; summing TAPS
    // products needs $clog2(TAPS) more bits to never overflow.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned w_w,
                                              input int unsigned taps);
        return data_w + 1 + w_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/pedometer_weight_file.sv
// pedometer_weight_file: TAPS x W_W FIR weight registers.
//   clk, reset            : clock, synchronous active-high reset
//   write_single          : data1 -> weight[addr1]
//   write_dual            : data1 -> weight[addr1], data2 -> weight[addr2];
//                           overrides write_single, data2 wins on equal addresses
//   addr1/addr2, data1/data2 : write addresses and data
//   weights               : all weights in parallel
// Addresses >= TAPS match no register, so such writes are dropped.
module pedometer_weight_file
    import pedometer_pkg::*;
#(
    parameter int unsigned W_W  = DEF_W_W,
    parameter int unsigned TAPS = DEF_TAPS,
    parameter int unsigned AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write_single,
    input  logic                      write_dual,
    input  logic [AW-1:0]             addr1,
    input  logic [AW-1:0]             addr2,
    input  logic [W_W-1:0]            data1,
    input  logic [W_W-1:0]            data2,
    output logic [TAPS-1:0][W_W-1:0]  weights
);

    always_ff @(posedge clk) begin
        if (reset) begin
            weights <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (write_dual) begin
                    if (addr2 == AW'(i)) begin
                        weights[i] <= data2;
                    end else if (addr1 == AW'(i)) begin
                        weights[i] <= data1;
                    end
                end else if (write_single && (addr1 == AW'(i))) begin
                    weights[i] <= data1;
                end
            end
        end
    end

endmodule

// File: rtl/pedometer_core.sv
// pedometer_core: two-axis magnitude -> TAPS-deep FIR -> hysteresis step counter.
//   clk, reset                 : clock, synchronous active-high reset
//   countSteps                 : enables detection; low forces ST_BELOW, holds count
//   updateWeight, dualUpdateWeights, Addr1/2, Data1/2 : weight file writes
//   A, B, sample_valid         : axis samples, accepted when sample_valid
//   thresh_hi, thresh_lo       : hysteresis thresholds (thresh_lo <= thresh_hi)
//   filt_out, filt_valid       : filtered magnitude and its one-cycle strobe
//   step_pulse, step_count     : per-step strobe and saturating total
// Optional feature macro PEDOMETER_DEBOUNCE_EN: after each counted step, the next
// MIN_GAP filtered samples cannot start a new step.
module pedometer_core
    import pedometer_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned W_W     = DEF_W_W,
    parameter int unsigned TAPS    = DEF_TAPS,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned MIN_GAP = DEF_MIN_GAP,
    parameter int unsigned ACC_W   = acc_width(DATA_W, W_W, TAPS),
    parameter int unsigned AW      = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              countSteps,
    input  logic              updateWeight,
    input  logic              dualUpdateWeights,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              sample_valid,
    input  logic [AW-1:0]     Addr1,
    input  logic [AW-1:0]     Addr2,
    input  logic [W_W-1:0]    Data1,
    input  logic [W_W-1:0]    Data2,
    input  logic [ACC_W-1:0]  thresh_hi,
    input  logic [ACC_W-1:0]  thresh_lo,
    output logic [ACC_W-1:0]  filt_out,
    output logic              filt_valid,
    output logic              step_pulse,
    output logic [CNT_W-1:0]  step_count
);

    localparam int unsigned MW = DATA_W + 1;

    logic [TAPS-1:0][W_W-1:0] weights;
    logic [TAPS-1:0][MW-1:0]  taps_q;
    logic [MW-1:0]            mag;
    logic                     sample_q;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         filt_q;
    logic                     filt_valid_q;
    det_state_e               state_q, state_d;
    logic                     step_q, step_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     gap_busy;

    pedometer_weight_file #(
        .W_W  (W_W),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_weight_file (
        .clk          (clk),
        .reset        (reset),
        .write_single (updateWeight),
        .write_dual   (dualUpdateWeights),
        .addr1        (Addr1),
        .addr2        (Addr2),
        .data1        (Data1),
        .data2        (Data2),
        .weights      (weights)
    );

    assign mag = MW'(A) + MW'(B);

    // Stage 1: delay line; sample_q marks that the line holds a fresh sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            taps_q   <= '0;
            sample_q <= 1'b0;
        end else begin
            sample_q <= sample_valid;
            if (sample_valid) begin
                taps_q[0] <= mag;
                for (int i = 1; i < TAPS; i++) begin
                    taps_q[i] <= taps_q[i-1];
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < TAPS; i++) begin
            acc = acc + ACC_W'(weights[i]) * ACC_W'(taps_q[i]);
        end
    end

    // Stage 2: registered filter result.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q       <= '0;
            filt_valid_q <= 1'b0;
        end else begin
            filt_valid_q <= sample_q;
            if (sample_q) begin
                filt_q <= acc;
            end
        end
    end

`ifdef PEDOMETER_DEBOUNCE_EN
    localparam int unsigned GW = $clog2(MIN_GAP + 2);
    logic [GW-1:0] gap_q, gap_d;

    assign gap_busy = (gap_q != '0);

    always_comb begin
        gap_d = gap_q;
        if (filt_valid_q) begin
            if (step_d) begin
                gap_d = GW'(MIN_GAP);
            end else if (gap_busy) begin
                gap_d = gap_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    assign gap_busy = 1'b0;
`endif

    // Stage 3: hysteresis detector, advanced only on filt_valid.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        count_d = count_q;
        if (!countSteps) begin
            state_d = ST_BELOW;
        end else if (filt_valid_q) begin
            unique case (state_q)
                ST_BELOW: begin
                    if ((filt_q > thresh_hi) && !gap_busy) begin
                        state_d = ST_ABOVE;
                        step_d  = 1'b1;
                        count_d = (&count_q) ? count_q : count_q + 1'b1;
                    end
                end
                ST_ABOVE: begin
                    if (filt_q < thresh_lo) begin
                        state_d = ST_BELOW;
                    end
                end
                default: state_d = ST_BELOW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BELOW;
            step_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

    assign filt_out   = filt_q;
    assign filt_valid = filt_valid_q;
    assign step_pulse = step_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_pedometer_core.sv
module tb_pedometer_core;

    localparam int DATA_W = 8;
    localparam int W_W    = 8;
    localparam int TAPS   = 8;
    localparam int AW     = 3;
    localparam int ACC_W  = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              countSteps = 1'b0;
    logic              updateWeight = 1'b0;
    logic              dualUpdateWeights = 1'b0;
    logic [DATA_W-1:0] A = '0;
    logic [DATA_W-1:0] B = '0;
    logic              sample_valid = 1'b0;
    logic [AW-1:0]     Addr1 = '0;
    logic [AW-1:0]     Addr2 = '0;
    logic [W_W-1:0]    Data1 = '0;
    logic [W_W-1:0]    Data2 = '0;
    logic [ACC_W-1:0]  thresh_hi = ACC_W'(120);
    logic [ACC_W-1:0]  thresh_lo = ACC_W'(60);

    logic [ACC_W-1:0]  filt_out, filt_out_s;
    logic              filt_valid, filt_valid_s;
    logic              step_pulse, step_pulse_s;
    logic [15:0]       step_count;
    logic [3:0]        step_count_s;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulse_cnt_s = 0;
    int fv_cnt = 0;

`ifdef PEDOMETER_DEBOUNCE_EN
    localparam bit DEBOUNCE = 1'b1;
`else
    localparam bit DEBOUNCE = 1'b0;
`endif

    always #5 clk = ~clk;

    pedometer_core #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .countSteps(countSteps),
        .updateWeight(updateWeight), .dualUpdateWeights(dualUpdateWeights),
        .A(A), .B(B), .sample_valid(sample_valid),
        .Addr1(Addr1), .Addr2(Addr2), .Data1(Data1), .Data2(Data2),
        .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
        .filt_out(filt_out), .filt_valid(filt_valid),
        .step_pulse(step_pulse), .step_count(step_count)
    );

    // Narrow-counter instance sharing all inputs, for saturation.
    pedometer_core #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .countSteps(countSteps),
        .updateWeight(updateWeight), .dualUpdateWeights(dualUpdateWeights),
        .A(A), .B(B), .sample_valid(sample_valid),
        .Addr1(Addr1), .Addr2(Addr2), .Data1(Data1), .Data2(Data2),
        .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
        .filt_out(filt_out_s), .filt_valid(filt_valid_s),
        .step_pulse(step_pulse_s), .step_count(step_count_s)
    );

    always @(negedge clk) begin
        if (step_pulse)   pulse_cnt++;
        if (step_pulse_s) pulse_cnt_s++;
        if (filt_valid)   fv_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_single(input int addr, input int data);
        updateWeight = 1'b1;
        Addr1 = AW'(addr);
        Data1 = W_W'(data);
        tick();
        updateWeight = 1'b0;
    endtask

    task automatic write_dual(input int a1, input int d1, input int a2, input int d2,
                              input bit single_too);
        dualUpdateWeights = 1'b1;
        updateWeight = single_too;
        Addr1 = AW'(a1);
        Data1 = W_W'(d1);
        Addr2 = AW'(a2);
        Data2 = W_W'(d2);
        tick();
        dualUpdateWeights = 1'b0;
        updateWeight = 1'b0;
    endtask

    // Present magnitude m split across both axes; caller controls sample_valid.
    task automatic set_mag(input int m);
        A = DATA_W'(m - m / 2);
        B = DATA_W'(m / 2);
    endtask

    // One isolated sample followed by enough idle cycles to reach step_pulse.
    task automatic send_isolated(input int m, output bit pulse_seen);
        set_mag(m);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        pulse_seen = step_pulse;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (filt_out !== '0)  begin errors++; $display("FAIL reset_filt_out got %0d want 0", filt_out); end
        checks++; if (filt_valid !== 1'b0) begin errors++; $display("FAIL reset_filt_valid got %b want 0", filt_valid); end
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step_pulse got %b want 0", step_pulse); end
        checks++; if (step_count !== '0) begin errors++; $display("FAIL reset_step_count got %0d want 0", step_count); end
    endtask

    task automatic test_single_write();
        do_reset();
        write_single(0, 1);
        set_mag(150);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        checks++; if (filt_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", filt_valid); end
        tick();
        checks++; if (filt_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", filt_valid); end
        checks++; if (filt_out !== ACC_W'(150)) begin errors++; $display("FAIL filt_150 got %0d want 150", filt_out); end
        tick();
        checks++; if (filt_valid !== 1'b0) begin errors++; $display("FAIL valid_strobe got %b want 0", filt_valid); end
        write_single(1, 2);
        set_mag(30);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        // taps = {30, 150}, weights = {1, 2}
        checks++; if (filt_out !== ACC_W'(330)) begin errors++; $display("FAIL fir_two_tap got %0d want 330", filt_out); end
    endtask

    task automatic test_dual_write_back_to_back();
        int seq[4] = '{1, 0, 3, 5};
        int fv_before;
        do_reset();
        write_dual(3, 5, 3, 9, 1'b1);
        write_dual(1, 6, 0, 2, 1'b0);
        fv_before = fv_cnt;
        for (int i = 0; i < 4; i++) begin
            set_mag(seq[i]);
            sample_valid = 1'b1;
            tick();
            // After the 4th edge, filt_out reflects taps {3,0,1,0} -> 2*3 = 6
            if (i == 3) begin
                checks++; if (filt_out !== ACC_W'(6)) begin errors++; $display("FAIL b2b_mid got %0d want 6", filt_out); end
            end
        end
        sample_valid = 1'b0;
        tick();
        // taps {5,3,0,1}, weights w0=2 w1=6 w3=9 -> 10 + 18 + 9
        checks++; if (filt_out !== ACC_W'(37)) begin errors++; $display("FAIL dual_fir got %0d want 37", filt_out); end
        tick();
        checks++; if (fv_cnt - fv_before !== 4) begin errors++; $display("FAIL b2b_strobes got %0d want 4", fv_cnt - fv_before); end
    endtask

    task automatic test_steps();
        int seq[5] = '{50, 150, 130, 40, 150};
        bit exp_pulse[5];
        bit seen;
        int p_before;
        exp_pulse = '{0, 1, 0, 0, !DEBOUNCE};
        do_reset();
        write_single(0, 1);
        countSteps = 1'b1;
        p_before = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            send_isolated(seq[i], seen);
            checks++;
            if (seen !== exp_pulse[i]) begin
                errors++;
                $display("FAIL step_pulse[%0d] got %b want %b", i, seen, exp_pulse[i]);
            end
        end
        checks++; if (step_count !== (DEBOUNCE ? 16'd1 : 16'd2)) begin errors++; $display("FAIL step_count got %0d want %0d", step_count, DEBOUNCE ? 1 : 2); end
        checks++; if (pulse_cnt - p_before !== (DEBOUNCE ? 1 : 2)) begin errors++; $display("FAIL pulse_total got %0d want %0d", pulse_cnt - p_before, DEBOUNCE ? 1 : 2); end
    endtask

    task automatic test_count_disable();
        int seq[5] = '{50, 150, 130, 40, 150};
        bit seen;
        int p_before;
        do_reset();
        write_single(0, 1);
        countSteps = 1'b0;
        p_before = pulse_cnt;
        for (int i = 0; i < 5; i++) send_isolated(seq[i], seen);
        checks++; if (step_count !== '0) begin errors++; $display("FAIL disabled_count got %0d want 0", step_count); end
        checks++; if (pulse_cnt !== p_before) begin errors++; $display("FAIL disabled_pulses got %0d want 0", pulse_cnt - p_before); end
        // filt_out is already 150 > thresh_hi; enabling counts on the next filt_valid.
        countSteps = 1'b1;
        send_isolated(150, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL reenable_pulse got %b want 1", seen); end
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL reenable_count got %0d want 1", step_count); end
    endtask

    task automatic test_debounce();
        int seq[3] = '{150, 40, 150};
        bit seen;
        do_reset();
        write_single(0, 1);
        countSteps = 1'b1;
        for (int i = 0; i < 3; i++) send_isolated(seq[i], seen);
        checks++; if (step_count !== (DEBOUNCE ? 16'd1 : 16'd2)) begin errors++; $display("FAIL debounce_count got %0d want %0d", step_count, DEBOUNCE ? 1 : 2); end
    endtask

    task automatic test_saturation_and_reset();
        int ps_before;
        int fv_before;
        do_reset();
        write_single(0, 1);
        countSteps = 1'b1;
        ps_before = pulse_cnt_s;
        // 17 crossings, back-to-back; four low samples let any debounce gap expire.
        for (int k = 0; k < 17; k++) begin
            for (int j = 0; j < 5; j++) begin
                set_mag(j == 0 ? 150 : 40);
                sample_valid = 1'b1;
                tick();
            end
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (step_count_s !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", step_count_s); end
        checks++; if (step_count !== 16'd17) begin errors++; $display("FAIL wide_count got %0d want 17", step_count); end
        checks++; if (pulse_cnt_s - ps_before !== 17) begin errors++; $display("FAIL sat_pulses got %0d want 17", pulse_cnt_s - ps_before); end

        // Sample accepted, then reset before its filt_valid would appear.
        set_mag(150);
        sample_valid = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (filt_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", filt_valid); end
        checks++; if (filt_out !== '0) begin errors++; $display("FAIL rst_mid_filt got %0d want 0", filt_out); end
        checks++; if (step_count !== '0 || step_count_s !== '0) begin errors++; $display("FAIL rst_mid_count got %0d/%0d want 0/0", step_count, step_count_s); end
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got %b want 0", step_pulse); end
        reset = 1'b0;
        sample_valid = 1'b0;
        fv_before = fv_cnt;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (fv_cnt !== fv_before) begin errors++; $display("FAIL rst_stray_valid got %0d want 0", fv_cnt - fv_before); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dual_write_back_to_back();
        test_steps();
        test_count_disable();
        test_debounce();
        test_saturation_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
